// File: rtl/bldc_regmap_pkg.sv
// Register map shared by the I2C slave and the BLDC PID register bank.
// Holds the address window bounds, per-register addresses, CTRL bit
// positions, reset values and the grouped PID parameter struct.
package bldc_regmap_pkg;

  localparam logic [7:0] WIN_LO           = 8'h40;
  localparam logic [7:0] WIN_HI           = 8'h53;

  localparam logic [7:0] ADDR_CTRL        = 8'h40;
  localparam logic [7:0] ADDR_STATUS      = 8'h41;
  localparam logic [7:0] ADDR_SETPOINT_LO = 8'h42;
  localparam logic [7:0] ADDR_SETPOINT_HI = 8'h43;
  localparam logic [7:0] ADDR_KP_LO       = 8'h44;
  localparam logic [7:0] ADDR_KP_HI       = 8'h45;
  localparam logic [7:0] ADDR_KI_LO       = 8'h46;
  localparam logic [7:0] ADDR_KI_HI       = 8'h47;
  localparam logic [7:0] ADDR_KD_LO       = 8'h48;
  localparam logic [7:0] ADDR_KD_HI       = 8'h49;
  localparam logic [7:0] ADDR_OUT_MAX_LO  = 8'h4A;
  localparam logic [7:0] ADDR_OUT_MAX_HI  = 8'h4B;
  localparam logic [7:0] ADDR_SPEED_LO    = 8'h4C;
  localparam logic [7:0] ADDR_SPEED_HI    = 8'h4D;
  localparam logic [7:0] ADDR_ERR_LO      = 8'h4E;
  localparam logic [7:0] ADDR_ERR_HI      = 8'h4F;
  localparam logic [7:0] ADDR_WR_CNT      = 8'h50;
  localparam logic [7:0] ADDR_SCRATCH     = 8'h51;
  localparam logic [7:0] ADDR_ID          = 8'h52;
  localparam logic [7:0] ADDR_RSVD        = 8'h53;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_DIR_BIT    = 1;
  localparam int CTRL_COMMIT_BIT = 7;

  localparam logic [7:0] WR_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic [15:0] setpoint;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic [15:0] out_max;
  } pid_cfg_t;

  localparam pid_cfg_t PID_CFG_RST = '{
    setpoint: 16'h0000,
    kp:       16'h0000,
    ki:       16'h0000,
    kd:       16'h0000,
    out_max:  16'hFFFF
  };

  function automatic logic in_window(input logic [7:0] idx);
    return (idx >= WIN_LO) && (idx <= WIN_HI);
  endfunction

endpackage

// File: rtl/i2c_reg_bank.sv
// Register bank between the I2C slave and the BLDC PID core.
// Decodes byte-wide write/read strobes over 0x40-0x53, stages PID
// configuration and transfers it to the active outputs on a commit.
// Speed/error hi bytes are snapshotted on the lo-byte read edge so a
// two-byte read is coherent.
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   wr, rd             level strobes from the slave (edge-detected here)
//   index, wdata       register address and write byte
//   rdata              registered read byte
//   speed_meas, pid_err, fault   telemetry inputs
//   enable, dir, setpoint, kp, ki, kd, out_max   active PID outputs
//   cfg_update         one-cycle pulse when the active set is reloaded
module i2c_reg_bank
  import bldc_regmap_pkg::*;
#(
  parameter logic [7:0] RO_ID = 8'hB1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  index,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic [15:0] speed_meas,
  input  logic [15:0] pid_err,
  input  logic [3:0]  fault,
  output logic        enable,
  output logic        dir,
  output logic [15:0] setpoint,
  output logic [15:0] kp,
  output logic [15:0] ki,
  output logic [15:0] kd,
  output logic [15:0] out_max,
  output logic        cfg_update
);

  logic        wr_q, rd_q, armed;
  logic        wr_fire, rd_fire;

  pid_cfg_t    stg, stg_nxt, act;
  logic        stg_en, stg_en_nxt;
  logic        stg_dir, stg_dir_nxt;
  logic [7:0]  scratch, scratch_nxt;
  logic        cfg_pending;
  logic [7:0]  wr_cnt;
  logic [7:0]  snap_hi;
  logic [7:0]  rd_mux;

  logic        wr_hit, pend_set, commit;

  // armed blocks a wr that is already high when reset releases from
  // being taken as a rising edge.
  assign wr_fire = wr & ~wr_q & armed;
  assign rd_fire = rd & ~rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      wr_q  <= wr;
      rd_q  <= rd;
      armed <= armed | ~wr;
    end
  end

  always_comb begin
    stg_nxt     = stg;
    stg_en_nxt  = stg_en;
    stg_dir_nxt = stg_dir;
    scratch_nxt = scratch;
    wr_hit      = 1'b0;
    pend_set    = 1'b0;
    commit      = 1'b0;
    if (wr_fire) begin
      wr_hit   = 1'b1;
      pend_set = 1'b1;
      case (index)
        ADDR_CTRL: begin
          stg_en_nxt  = wdata[CTRL_EN_BIT];
          stg_dir_nxt = wdata[CTRL_DIR_BIT];
          commit      = wdata[CTRL_COMMIT_BIT];
        end
        ADDR_SETPOINT_LO: stg_nxt.setpoint[7:0]  = wdata;
        ADDR_SETPOINT_HI: stg_nxt.setpoint[15:8] = wdata;
        ADDR_KP_LO:       stg_nxt.kp[7:0]        = wdata;
        ADDR_KP_HI:       stg_nxt.kp[15:8]       = wdata;
        ADDR_KI_LO:       stg_nxt.ki[7:0]        = wdata;
        ADDR_KI_HI:       stg_nxt.ki[15:8]       = wdata;
        ADDR_KD_LO:       stg_nxt.kd[7:0]        = wdata;
        ADDR_KD_HI:       stg_nxt.kd[15:8]       = wdata;
        ADDR_OUT_MAX_LO:  stg_nxt.out_max[7:0]   = wdata;
        ADDR_OUT_MAX_HI:  stg_nxt.out_max[15:8]  = wdata;
        ADDR_SCRATCH: begin
          scratch_nxt = wdata;
          pend_set    = 1'b0;
        end
        default: begin
          wr_hit   = 1'b0;
          pend_set = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg         <= PID_CFG_RST;
      stg_en      <= 1'b0;
      stg_dir     <= 1'b0;
      scratch     <= 8'h00;
      act         <= PID_CFG_RST;
      enable      <= 1'b0;
      dir         <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_update  <= 1'b0;
      wr_cnt      <= 8'h00;
    end else begin
      stg        <= stg_nxt;
      stg_en     <= stg_en_nxt;
      stg_dir    <= stg_dir_nxt;
      scratch    <= scratch_nxt;
      cfg_update <= commit;
      // Commit takes the _nxt values so CTRL bits written in the same
      // byte are included.
      if (commit) begin
        act         <= stg_nxt;
        enable      <= stg_en_nxt;
        dir         <= stg_dir_nxt;
        cfg_pending <= 1'b0;
      end else if (pend_set) begin
        cfg_pending <= 1'b1;
      end
      if (wr_hit && (wr_cnt != WR_CNT_MAX))
        wr_cnt <= wr_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_hi <= 8'h00;
    end else if (rd_fire) begin
      if (index == ADDR_SPEED_LO)
        snap_hi <= speed_meas[15:8];
      else if (index == ADDR_ERR_LO)
        snap_hi <= pid_err[15:8];
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (index)
      ADDR_CTRL:        rd_mux = {6'b0, stg_dir, stg_en};
      ADDR_STATUS:      rd_mux = {3'b0, cfg_pending, fault};
      ADDR_SETPOINT_LO: rd_mux = stg.setpoint[7:0];
      ADDR_SETPOINT_HI: rd_mux = stg.setpoint[15:8];
      ADDR_KP_LO:       rd_mux = stg.kp[7:0];
      ADDR_KP_HI:       rd_mux = stg.kp[15:8];
      ADDR_KI_LO:       rd_mux = stg.ki[7:0];
      ADDR_KI_HI:       rd_mux = stg.ki[15:8];
      ADDR_KD_LO:       rd_mux = stg.kd[7:0];
      ADDR_KD_HI:       rd_mux = stg.kd[15:8];
      ADDR_OUT_MAX_LO:  rd_mux = stg.out_max[7:0];
      ADDR_OUT_MAX_HI:  rd_mux = stg.out_max[15:8];
      ADDR_SPEED_LO:    rd_mux = speed_meas[7:0];
      ADDR_SPEED_HI:    rd_mux = snap_hi;
      ADDR_ERR_LO:      rd_mux = pid_err[7:0];
      ADDR_ERR_HI:      rd_mux = snap_hi;
      ADDR_WR_CNT:      rd_mux = wr_cnt;
      ADDR_SCRATCH:     rd_mux = scratch;
      ADDR_ID:          rd_mux = RO_ID;
      default:          rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= 8'h00;
    else
      rdata <= rd_mux;
  end

  assign setpoint = act.setpoint;
  assign kp       = act.kp;
  assign ki       = act.ki;
  assign kd       = act.kd;
  assign out_max  = act.out_max;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: reset behaviour, staging/commit,
// RO/out-of-window writes, read snapshots, ID/reserved, WR_CNT saturation
// and a mid-transaction reset.
module tb_i2c_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr, rd;
  logic [7:0]  index, wdata, rdata;
  logic [15:0] speed_meas, pid_err;
  logic [3:0]  fault;
  logic        enable, dir, cfg_update;
  logic [15:0] setpoint, kp, ki, kd, out_max;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int u0;
  logic [7:0] d;
  logic [7:0] last_scr;

  always #5 clk = ~clk;

  i2c_reg_bank #(.RO_ID(8'hB1)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .index(index),
    .wdata(wdata), .rdata(rdata), .speed_meas(speed_meas),
    .pid_err(pid_err), .fault(fault), .enable(enable), .dir(dir),
    .setpoint(setpoint), .kp(kp), .ki(ki), .kd(kd), .out_max(out_max),
    .cfg_update(cfg_update)
  );

  always @(negedge clk) if (rst_n && cfg_update) upd_cnt++;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] v,
                        input int hold);
    @(negedge clk);
    index = a; wdata = v; wr = 1'b1;
    repeat (hold) @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    index = a;
    @(negedge clk);
    v = rdata;
  endtask

  task automatic snap_rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    index = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    v = rdata;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b1; rd = 1'b0; index = 8'h51; wdata = 8'h55;
    speed_meas = 16'h0; pid_err = 16'h0; fault = 4'h5;

    repeat (3) @(negedge clk);
    check("rst_rdata", {8'h0, rdata}, 16'h0000);
    check("rst_out_max", out_max, 16'hFFFF);
    check("rst_cfg_update", {15'h0, cfg_update}, 16'h0000);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    rd_reg(8'h50, d); check("rst_wr_cnt", {8'h0, d}, 16'h0000);
    rd_reg(8'h51, d); check("rst_scratch", {8'h0, d}, 16'h0000);

    wr_reg(8'h44, 8'h34, 5);
    wr_reg(8'h45, 8'h12, 5);
    check("kp_staged_only", kp, 16'h0000);
    rd_reg(8'h41, d); check("status_pending", {8'h0, d}, 16'h0015);
    rd_reg(8'h50, d); check("wr_cnt_2", {8'h0, d}, 16'h0002);
    rd_reg(8'h45, d); check("kp_hi_readback", {8'h0, d}, 16'h0012);

    u0 = upd_cnt;
    wr_reg(8'h40, 8'h83, 1);
    check("commit_kp", kp, 16'h1234);
    check("commit_enable", {15'h0, enable}, 16'h0001);
    check("commit_dir", {15'h0, dir}, 16'h0001);
    check("commit_pulses", 16'(upd_cnt - u0), 16'h0001);
    rd_reg(8'h41, d); check("status_clear", {8'h0, d}, 16'h0005);
    rd_reg(8'h40, d); check("ctrl_readback", {8'h0, d}, 16'h0003);

    // Commit latency: outputs move on the first edge after wr rises.
    @(negedge clk);
    index = 8'h40; wdata = 8'h80; wr = 1'b1;
    @(posedge clk); #1;
    check("commit_lat_en", {15'h0, enable}, 16'h0000);
    check("commit_lat_upd", {15'h0, cfg_update}, 16'h0001);
    @(posedge clk); #1;
    check("commit_one_cycle", {15'h0, cfg_update}, 16'h0000);
    @(negedge clk); wr = 1'b0;
    @(negedge clk);

    wr_reg(8'h44, 8'h77, 2);
    rd_reg(8'h44, d); check("staged_readback", {8'h0, d}, 16'h0077);
    check("active_kept", kp, 16'h1234);

    wr_reg(8'h4C, 8'hEE, 1);
    wr_reg(8'h60, 8'hEE, 1);
    rd_reg(8'h50, d); check("ro_oow_wr_cnt", {8'h0, d}, 16'h0005);

    speed_meas = 16'h0A0B;
    snap_rd(8'h4C, d); check("speed_lo", {8'h0, d}, 16'h000B);
    speed_meas = 16'hFFFF;
    rd_reg(8'h4D, d); check("speed_hi_snap", {8'h0, d}, 16'h000A);
    pid_err = 16'h8001;
    snap_rd(8'h4E, d); check("err_lo", {8'h0, d}, 16'h0001);
    pid_err = 16'h0000;
    rd_reg(8'h4F, d); check("err_hi_snap", {8'h0, d}, 16'h0080);

    rd_reg(8'h52, d); check("id", {8'h0, d}, 16'h00B1);
    rd_reg(8'h53, d); check("reserved", {8'h0, d}, 16'h0000);

    last_scr = 8'h00;
    for (int i = 0; i < 300; i++) begin
      last_scr = 8'(i) ^ 8'h5A;
      wr_reg(8'h51, last_scr, 1);
    end
    rd_reg(8'h50, d); check("wr_cnt_sat", {8'h0, d}, 16'h00FF);
    rd_reg(8'h51, d); check("scratch_last", {8'h0, d}, {8'h0, last_scr});

    // Reset in the middle of a write, released with wr still high.
    @(negedge clk);
    index = 8'h51; wdata = 8'hC3; wr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_kp", kp, 16'h0000);
    check("midrst_out_max", out_max, 16'hFFFF);
    check("midrst_rdata", {8'h0, rdata}, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wr = 1'b0;
    rd_reg(8'h51, d); check("midrst_scratch", {8'h0, d}, 16'h0000);
    rd_reg(8'h50, d); check("midrst_wr_cnt", {8'h0, d}, 16'h0000);

    wr_reg(8'h51, 8'h3C, 1);
    rd_reg(8'h51, d); check("post_rst_write", {8'h0, d}, 16'h003C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
